ahb_dma_mc: RTL and testbench

//  Multi-channel AHB DMA controller, next generation of the single-channel DMA.
//  An AHB-Lite slave port holds per-channel registers; one shared AHB master port

---
 rtl/ahb_dma_mc_if.sv | 29 ++
 rtl/ahb_dma_mc.sv | 230 +++++++++++++++++++++++
 tb/tb_ahb_dma_mc.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_dma_mc_if.sv
// AHB bus bundle used for both the register (slave) port and the shared DMA master port.
interface ahb_dma_mc_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic                  HBUSREQ;
  logic                  HGRANT;

  modport master (
    output HBUSREQ, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HGRANT, HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_dma_mc.sv
// Multi-channel AHB DMA: per-channel register file on an AHB-Lite slave port and one shared
// master port moving single words memory-to-memory, channels served round-robin.
module ahb_dma_mc #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_CH     = 2,
  parameter int unsigned           CNT_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0020_0000
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_dma_mc_if.slave       s_bus,
  ahb_dma_mc_if.master      m_bus,
  output logic              irq
);
  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_WIDTH-1:0] Step = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [2:0] {StIdle, StReq, StRdA, StRdD, StWrA, StWrD} state_e;

  state_e                            state_q, state_d;
  logic                              dp_valid_q, dp_write_q;
  logic [ADDR_WIDTH-1:0]             dp_addr_q;
  logic [NUM_CH-1:0][3:0]            ctrl_q, ctrl_d;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, wsrc_q, wsrc_d, wdst_q, wdst_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d, wcnt_q, wcnt_d;
  logic [NUM_CH-1:0]                 done_q, done_d, err_q, err_d, en_vec;
  logic [NUM_CH-1:0]                 done_set, done_clr, err_set, err_clr;
  logic                              kill_q, kill_d, hwrite_q, hwrite_d, busreq, wr_en;
  logic [ChW-1:0]                    cur_q, cur_d, last_q, last_d, sel, rch;
  logic [ADDR_WIDTH-1:0]             haddr_q, haddr_d, off;
  logic [ADDR_WIDTH-3:0]             woff;
  logic [DATA_WIDTH-1:0]             hwdata_q, hwdata_d, rdata, status;
  logic [1:0]                        htrans, rsel;
  logic                              hit_ch, hit_st, found, unused_ok;

  assign wr_en     = dp_valid_q & dp_write_q;
  assign off       = dp_addr_q - BASE_ADDR;
  assign woff      = off[ADDR_WIDTH-1:2];
  assign hit_ch    = woff < (ADDR_WIDTH-2)'(NUM_CH * 4);
  assign hit_st    = woff == (ADDR_WIDTH-2)'(64);
  assign rch       = woff[2 +: ChW];
  assign rsel      = woff[1:0];
  assign unused_ok = ^{off[1:0], s_bus.HTRANS[0]};

  always_comb begin
    status = '0;
    status[NUM_CH-1:0] = done_q;
    status[8 +: NUM_CH] = err_q;
    irq = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      en_vec[c] = ctrl_q[c][0];
      irq = irq | ((done_q[c] | err_q[c]) & ctrl_q[c][1]);
    end
  end

  // Round-robin: first enabled channel strictly after the last one served.
  always_comb begin
    sel   = last_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      logic [ChW-1:0] idx;
      idx = ChW'((32'(last_q) + i) % NUM_CH);
      if (!found && en_vec[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (dp_valid_q && !dp_write_q) begin
      if (hit_ch) begin
        case (rsel)
          2'd0:    rdata = DATA_WIDTH'(ctrl_q[rch]);
          2'd1:    rdata = DATA_WIDTH'(src_q[rch]);
          2'd2:    rdata = DATA_WIDTH'(dst_q[rch]);
          default: rdata = DATA_WIDTH'(cnt_q[rch]);
        endcase
      end else if (hit_st) begin
        rdata = status;
      end
    end
  end

  always_comb begin
    ctrl_d = ctrl_q; src_d = src_q; dst_d = dst_q; cnt_d = cnt_q;
    wsrc_d = wsrc_q; wdst_d = wdst_q; wcnt_d = wcnt_q;
    done_set = '0; done_clr = '0; err_set = '0; err_clr = '0;
    kill_d = (state_q == StIdle) ? 1'b0 : kill_q;
    state_d = state_q; cur_d = cur_q; last_d = last_q;
    haddr_d = haddr_q; hwrite_d = hwrite_q; hwdata_d = hwdata_q;
    busreq = 1'b0; htrans = 2'b00;

    if (wr_en && hit_ch) begin
      case (rsel)
        2'd0: begin
          ctrl_d[rch] = s_bus.HWDATA[3:0];
          if (!ctrl_q[rch][0] && s_bus.HWDATA[0]) begin
            wsrc_d[rch] = src_q[rch];
            wdst_d[rch] = dst_q[rch];
            wcnt_d[rch] = cnt_q[rch];
            if (cnt_q[rch] == '0) begin
              ctrl_d[rch][0] = 1'b0;
              done_set[rch]  = 1'b1;
            end
          end
          // Disabling the channel that owns the in-flight word lets that word finish silently.
          if (ctrl_q[rch][0] && !s_bus.HWDATA[0] && cur_q == rch &&
              state_q inside {StRdA, StRdD, StWrA, StWrD}) begin
            kill_d = 1'b1;
          end
        end
        2'd1:    if (!ctrl_q[rch][0]) src_d[rch] = s_bus.HWDATA[ADDR_WIDTH-1:0];
        2'd2:    if (!ctrl_q[rch][0]) dst_d[rch] = s_bus.HWDATA[ADDR_WIDTH-1:0];
        default: if (!ctrl_q[rch][0]) cnt_d[rch] = s_bus.HWDATA[CNT_WIDTH-1:0];
      endcase
    end
    if (wr_en && hit_st) begin
      done_clr = s_bus.HWDATA[NUM_CH-1:0];
      err_clr  = s_bus.HWDATA[8 +: NUM_CH];
    end

    unique case (state_q)
      StIdle: if (|en_vec) begin
        cur_d   = sel;
        last_d  = sel;
        state_d = StReq;
      end
      StReq: begin
        busreq = 1'b1;
        if (!ctrl_q[cur_q][0]) begin
          state_d = StIdle;
        end else if (m_bus.HGRANT && m_bus.HREADY) begin
          state_d  = StRdA;
          haddr_d  = wsrc_q[cur_q];
          hwrite_d = 1'b0;
        end
      end
      StRdA: begin
        busreq  = 1'b1;
        htrans  = 2'b10;
        state_d = StRdD;
      end
      StRdD: begin
        busreq = 1'b1;
        if (m_bus.HREADY) begin
          if (m_bus.HRESP) begin
            state_d = StIdle;
            if (!kill_q) begin
              ctrl_d[cur_q][0] = 1'b0;
              err_set[cur_q]   = 1'b1;
            end
          end else begin
            hwdata_d = m_bus.HRDATA;
            haddr_d  = wdst_q[cur_q];
            hwrite_d = 1'b1;
            state_d  = StWrA;
          end
        end
      end
      StWrA: begin
        busreq  = 1'b1;
        htrans  = 2'b10;
        state_d = StWrD;
      end
      StWrD: if (m_bus.HREADY) begin
        state_d = StIdle;
        if (!kill_q) begin
          if (m_bus.HRESP) begin
            ctrl_d[cur_q][0] = 1'b0;
            err_set[cur_q]   = 1'b1;
          end else begin
            if (ctrl_q[cur_q][2]) wsrc_d[cur_q] = wsrc_q[cur_q] + Step;
            if (ctrl_q[cur_q][3]) wdst_d[cur_q] = wdst_q[cur_q] + Step;
            wcnt_d[cur_q] = wcnt_q[cur_q] - CNT_WIDTH'(1);
            if (wcnt_q[cur_q] == CNT_WIDTH'(1)) begin
              ctrl_d[cur_q][0] = 1'b0;
              done_set[cur_q]  = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    done_d = (done_q & ~done_clr) | done_set;
    err_d  = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
    end else if (s_bus.HREADY) begin
      dp_valid_q <= s_bus.HSEL & s_bus.HTRANS[1];
      dp_write_q <= s_bus.HWRITE;
      dp_addr_q  <= s_bus.HADDR;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q <= '0; src_q <= '0; dst_q <= '0; cnt_q <= '0;
      wsrc_q <= '0; wdst_q <= '0; wcnt_q <= '0;
      done_q <= '0; err_q <= '0; kill_q <= 1'b0;
      state_q <= StIdle; cur_q <= '0; last_q <= ChW'(NUM_CH - 1);
      haddr_q <= '0; hwrite_q <= 1'b0; hwdata_q <= '0;
    end else begin
      ctrl_q <= ctrl_d; src_q <= src_d; dst_q <= dst_d; cnt_q <= cnt_d;
      wsrc_q <= wsrc_d; wdst_q <= wdst_d; wcnt_q <= wcnt_d;
      done_q <= done_d; err_q <= err_d; kill_q <= kill_d;
      state_q <= state_d; cur_q <= cur_d; last_q <= last_d;
      haddr_q <= haddr_d; hwrite_q <= hwrite_d; hwdata_q <= hwdata_d;
    end
  end

  assign s_bus.HREADYOUT = 1'b1;
  assign s_bus.HRESP     = 1'b0;
  assign s_bus.HRDATA    = rdata;
  assign m_bus.HBUSREQ   = busreq;
  assign m_bus.HTRANS    = htrans;
  assign m_bus.HADDR     = haddr_q;
  assign m_bus.HWRITE    = hwrite_q;
  assign m_bus.HWDATA    = hwdata_q;
  assign m_bus.HSIZE     = 3'b010;
  assign m_bus.HBURST    = 3'b000;
endmodule

// File: tb/tb_ahb_dma_mc.sv
// Bench for ahb_dma_mc: register-port driver, memory model on the master port and a
// scoreboard of expected master beats checked as the DUT issues them.
module tb_ahb_dma_mc;
  localparam logic [31:0] Base   = 32'h0020_0000;
  localparam logic [31:0] StatA  = Base + 32'h100;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic irq;
  int   checks = 0;
  int   errors = 0;
  int   waits = 0;
  int   busreq_cycles = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  beat_t sb_q[$];

  always #5 HCLK = ~HCLK;

  ahb_dma_mc_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();
  ahb_dma_mc_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_bus ();

  ahb_dma_mc #(.NUM_CH(2)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .s_bus  (s_bus),
    .m_bus  (m_bus),
    .irq    (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] reg_a(input int ch, input int offs);
    return Base + 32'(ch * 16 + offs);
  endfunction

  // Master-side memory: reads return rd_pat(addr), optional waits and a two-cycle error reply.
  logic        dp_valid, dp_write;
  logic [31:0] dp_addr, dp_exp;
  int          wcnt;
  beat_t       exp_beat;

  always @(posedge HCLK) if (m_bus.HBUSREQ === 1'b1) busreq_cycles++;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid     <= 1'b0;
      dp_write     <= 1'b0;
      dp_addr      <= '0;
      dp_exp       <= '0;
      wcnt         <= 0;
      m_bus.HREADY <= 1'b1;
      m_bus.HRESP  <= 1'b0;
      m_bus.HRDATA <= '0;
    end else if (m_bus.HREADY) begin
      if (dp_valid && dp_write) check_eq("wr_data", m_bus.HWDATA, dp_exp);
      m_bus.HRESP <= 1'b0;
      if (m_bus.HTRANS[1]) begin
        dp_valid <= 1'b1;
        dp_write <= m_bus.HWRITE;
        dp_addr  <= m_bus.HADDR;
        if (sb_q.size() == 0) begin
          check_eq("unexpected_beat", m_bus.HADDR, 32'hFFFF_FFFF);
          dp_exp <= '0;
        end else begin
          exp_beat = sb_q.pop_front();
          check_eq("beat_addr", m_bus.HADDR, exp_beat.addr);
          check_eq("beat_dir", {31'b0, m_bus.HWRITE}, {31'b0, exp_beat.wr});
          dp_exp <= exp_beat.data;
        end
        if (!m_bus.HWRITE && m_bus.HADDR == err_addr) begin
          m_bus.HREADY <= 1'b0;
          m_bus.HRESP  <= 1'b1;
          wcnt         <= 0;
        end else if (waits > 0) begin
          m_bus.HREADY <= 1'b0;
          wcnt         <= waits;
        end else begin
          m_bus.HRDATA <= rd_pat(m_bus.HADDR);
        end
      end else begin
        dp_valid <= 1'b0;
      end
    end else begin
      if (wcnt <= 1) begin
        m_bus.HREADY <= 1'b1;
        m_bus.HRDATA <= rd_pat(dp_addr);
      end
      wcnt <= wcnt - 1;
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    s_bus.HSEL = 1'b1; s_bus.HTRANS = 2'b10; s_bus.HWRITE = 1'b1; s_bus.HADDR = addr;
    @(posedge HCLK); #1;
    s_bus.HSEL = 1'b0; s_bus.HTRANS = 2'b00; s_bus.HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    s_bus.HSEL = 1'b1; s_bus.HTRANS = 2'b10; s_bus.HWRITE = 1'b0; s_bus.HADDR = addr;
    @(posedge HCLK); #1;
    s_bus.HSEL = 1'b0; s_bus.HTRANS = 2'b00;
    data = s_bus.HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check_eq(tag, d, exp);
  endtask

  task automatic push_word(input logic [31:0] s, input logic [31:0] d);
    sb_q.push_back('{wr: 1'b0, addr: s, data: 32'h0});
    sb_q.push_back('{wr: 1'b1, addr: d, data: rd_pat(s)});
  endtask

  // Poll STATUS until the mask bits are all set or the budget runs out.
  task automatic wait_status(input logic [31:0] mask, output logic [31:0] st);
    int n = 0;
    do begin
      bus_read(StatA, st);
      n++;
    end while ((st & mask) != mask && n < 400);
  endtask

  task automatic setup_ch(input int ch, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] n);
    bus_write(reg_a(ch, 4), s);
    bus_write(reg_a(ch, 8), d);
    bus_write(reg_a(ch, 12), n);
  endtask

  initial begin
    logic [31:0] st;
    int b0, n;
    HRESETn = 1'b0;
    s_bus.HSEL = 1'b0; s_bus.HTRANS = 2'b00; s_bus.HWRITE = 1'b0; s_bus.HADDR = '0;
    s_bus.HWDATA = '0; s_bus.HREADY = 1'b1; s_bus.HGRANT = 1'b0; s_bus.HBUSREQ = 1'b0;
    s_bus.HSIZE = 3'b010; s_bus.HBURST = 3'b000;
    m_bus.HGRANT = 1'b1; m_bus.HSEL = 1'b0; m_bus.HREADYOUT = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    check_eq("rst_htrans", {30'b0, m_bus.HTRANS}, 32'h0);
    check_eq("rst_hsize", {29'b0, m_bus.HSIZE}, 32'h2);
    check_eq("rst_busreq", {31'b0, m_bus.HBUSREQ}, 32'h0);
    read_check("rst_ctrl0", reg_a(0, 0), 32'h0);
    read_check("rst_status", StatA, 32'h0);

    // 1: four words, both addresses incrementing
    setup_ch(0, 32'h1000, 32'h2000, 32'd4);
    for (int i = 0; i < 4; i++) push_word(32'h1000 + 32'(4 * i), 32'h2000 + 32'(4 * i));
    bus_write(reg_a(0, 0), 32'hF);
    wait_status(32'h1, st);
    check_eq("t1_status", st, 32'h1);
    check_eq("t1_irq", {31'b0, irq}, 32'h1);
    check_eq("t1_sb_left", sb_q.size(), 0);
    read_check("t1_ctrl", reg_a(0, 0), 32'hE);
    bus_write(StatA, 32'h1);
    check_eq("t1_irq_clr", {31'b0, irq}, 32'h0);

    // 2: two channels interleave word by word
    setup_ch(0, 32'h4000, 32'h5000, 32'd3);
    setup_ch(1, 32'h6000, 32'h7000, 32'd3);
    for (int i = 0; i < 3; i++) begin
      push_word(32'h4000 + 32'(4 * i), 32'h5000 + 32'(4 * i));
      push_word(32'h6000 + 32'(4 * i), 32'h7000 + 32'(4 * i));
    end
    bus_write(reg_a(0, 0), 32'hD);
    bus_write(reg_a(1, 0), 32'hD);
    wait_status(32'h3, st);
    check_eq("t2_status", st, 32'h3);
    check_eq("t2_sb_left", sb_q.size(), 0);
    check_eq("t2_irq_no_ie", {31'b0, irq}, 32'h0);
    bus_write(StatA, 32'h3);

    // 3: fixed destination with two wait states per beat
    waits = 2;
    setup_ch(0, 32'h8000, 32'h3000, 32'd4);
    for (int i = 0; i < 4; i++) push_word(32'h8000 + 32'(4 * i), 32'h3000);
    bus_write(reg_a(0, 0), 32'h5);
    wait_status(32'h1, st);
    check_eq("t3_status", st, 32'h1);
    check_eq("t3_sb_left", sb_q.size(), 0);
    bus_write(StatA, 32'h1);
    waits = 0;

    // 4: error on the second read aborts with ERR, no write for that word
    err_addr = 32'h9004;
    setup_ch(0, 32'h9000, 32'hA000, 32'd4);
    push_word(32'h9000, 32'hA000);
    sb_q.push_back('{wr: 1'b0, addr: 32'h9004, data: 32'h0});
    bus_write(reg_a(0, 0), 32'hF);
    wait_status(32'h100, st);
    repeat (10) @(posedge HCLK);
    #1;
    check_eq("t4_status", st, 32'h100);
    check_eq("t4_sb_left", sb_q.size(), 0);
    check_eq("t4_irq", {31'b0, irq}, 32'h1);
    read_check("t4_ctrl", reg_a(0, 0), 32'hE);
    bus_write(StatA, 32'h100);
    read_check("t4_status_clr", StatA, 32'h0);
    check_eq("t4_irq_clr", {31'b0, irq}, 32'h0);
    err_addr = 32'hFFFF_FFFF;

    // 5: zero count completes at once without a bus request
    b0 = busreq_cycles;
    bus_write(reg_a(0, 12), 32'd0);
    bus_write(reg_a(0, 0), 32'h3);
    read_check("t5_status", StatA, 32'h1);
    check_eq("t5_irq", {31'b0, irq}, 32'h1);
    read_check("t5_ctrl", reg_a(0, 0), 32'h2);
    repeat (10) @(posedge HCLK);
    #1;
    check_eq("t5_no_busreq", 32'(busreq_cycles - b0), 32'h0);
    bus_write(StatA, 32'h1);

    // 5b: SRC write while the channel is active is ignored
    waits = 8;
    setup_ch(1, 32'hB000, 32'hC000, 32'd2);
    push_word(32'hB000, 32'hC000);
    push_word(32'hB004, 32'hC004);
    bus_write(reg_a(1, 0), 32'hD);
    bus_write(reg_a(1, 4), 32'hDEAD_0000);
    read_check("t5_src_locked", reg_a(1, 4), 32'hB000);
    wait_status(32'h2, st);
    check_eq("t5b_status", st, 32'h2);
    check_eq("t5b_sb_left", sb_q.size(), 0);
    bus_write(StatA, 32'h2);

    // 6: reset asserted while a read data phase is stalled
    waits = 6;
    setup_ch(0, 32'hD000, 32'hE000, 32'd4);
    for (int i = 0; i < 4; i++) push_word(32'hD000 + 32'(4 * i), 32'hE000 + 32'(4 * i));
    bus_write(reg_a(0, 0), 32'hF);
    n = 0;
    while (!(m_bus.HTRANS == 2'b10 && m_bus.HWRITE == 1'b0) && n < 100) begin
      @(posedge HCLK); #1;
      n++;
    end
    check_eq("t6_saw_read", {31'b0, n < 100}, 32'h1);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    #1;
    check_eq("t6_htrans", {30'b0, m_bus.HTRANS}, 32'h0);
    check_eq("t6_busreq", {31'b0, m_bus.HBUSREQ}, 32'h0);
    check_eq("t6_haddr", m_bus.HADDR, 32'h0);
    check_eq("t6_irq", {31'b0, irq}, 32'h0);
    sb_q.delete();
    waits = 0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    read_check("t6_ctrl0", reg_a(0, 0), 32'h0);
    read_check("t6_src0", reg_a(0, 4), 32'h0);
    read_check("t6_dst0", reg_a(0, 8), 32'h0);
    read_check("t6_cnt0", reg_a(0, 12), 32'h0);
    read_check("t6_src1", reg_a(1, 4), 32'h0);
    read_check("t6_status", StatA, 32'h0);
    repeat (10) @(posedge HCLK);
    #1;
    check_eq("t6_idle_busreq", {31'b0, m_bus.HBUSREQ}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
